data_ram_ctl: RTL and testbench

DATA_RAM_CTL -- requirements
Module: data_ram_ctl

---
 rtl/data_ram_ctl.sv | 175 +++++++++++++++++
 tb/tb_data_ram_ctl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctl.sv
// -----------------------------------------------------------------------------
// data_ram_ctl
//
// Single-port word RAM with byte-enable writes and a one-cycle registered
// response. A small two-state FSM (CLEAR / READY) zero-fills the whole array
// one word per cycle after reset (when INIT_CLEAR = 1) and on clear_req.
// Requests are only accepted in READY. Out-of-range addresses return an
// error response and leave memory untouched.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : request can be accepted this cycle (READY state)
//   req_write  : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   req_be     : byte enables, bit i covers byte i
//   clear_req  : start a full zero-fill (honoured in READY only)
//   busy       : zero-fill in progress (CLEAR state)
//   rsp_valid  : one-cycle response pulse, the cycle after an accept
//   rsp_rdata  : read data (0 for writes, errors and idle cycles)
//   rsp_err    : address out of range
// -----------------------------------------------------------------------------
module data_ram_ctl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 256,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                clear_req,
  output logic                busy,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam state_e RESET_STATE = INIT_CLEAR ? CLEAR : READY;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               in_range;
  logic [IDX_W-1:0]   req_idx;
  logic [DATA_W-1:0]  rd_word;
  logic               clr_last;
  logic               clr_we;
  logic               req_we;

  // Full-width compare so addresses beyond the index width are caught too.
  assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign req_idx  = req_addr[IDX_W-1:0];
  assign clr_last = (clr_ptr_q == IDX_W'(DEPTH - 1));
  assign accept   = req_valid && req_ready;
  assign req_we   = accept && req_write && in_range;
  // The state register sits in CLEAR while reset is held; do not let that
  // scrub word 0 on clock edges that occur during reset.
  assign clr_we   = busy;

  // Read port sees the contents before the accept edge.
  assign rd_word  = mem[req_idx];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = '0;
    unique case (state_q)
      CLEAR: begin
        // clear_req is deliberately ignored here: a fill is never restarted.
        if (clr_last) begin
          state_d   = READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      READY: begin
        if (clear_req) state_d = CLEAR;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Gated by rst_n so both read 0 while reset is asserted, even
  // though the state register already holds the post-reset state.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = rst_n && (state_q == CLEAR);
    req_ready = rst_n && (state_q == READY);
  end

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; its contents are defined only by the
  // zero-fill and by writes, which also lets it map onto RAM macros.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr_q] <= '0;
    end else if (req_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path: one registered cycle after the accept edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && !in_range;
    rsp_rdata_d = '0;
    if (accept && !req_write && in_range) rsp_rdata_d = rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_ram_ctl.sv
// -----------------------------------------------------------------------------
// tb_data_ram_ctl
//
// Self-checking bench for data_ram_ctl at default parameters. Each request
// pushes its expected response (cycle, data, error) onto a scoreboard queue;
// a monitor running on the falling edge pops and compares every response
// pulse. Feature tasks check busy timing, reset behaviour and idle outputs.
// -----------------------------------------------------------------------------
module tb_data_ram_ctl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  logic                clk;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic                clear_req;
  logic                busy;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  data_ram_ctl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_CLEAR(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .clear_req (clear_req),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned       cyc;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  rsp_t              sb[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  int unsigned       cyc;
  int                tests_run;
  int                tests_failed;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rsp_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          tests_failed++;
          $display("FAIL rsp: got cycle=%0d rdata=%h err=%b, required cycle=%0d rdata=%h err=%b",
                   cyc, rsp_rdata, rsp_err, e.cyc, e.rdata, e.err);
        end
      end
    end else begin
      tests_run++;
      if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_rsp: got rdata=%h err=%b with rsp_valid=0, required 0/0",
                 rsp_rdata, rsp_err);
      end
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request starting just after a rising edge; it is accepted on the
  // next rising edge. The expected response is computed from the model here.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [DATA_W/8-1:0] be);
    rsp_t e;
    logic err;
    err = (addr >= ADDR_W'(DEPTH));
    e.cyc   = cyc + 1;
    e.err   = err;
    e.rdata = '0;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_ready: got req_ready=%b before request to %h, required 1", req_ready, addr);
    end
    if (!err) begin
      if (!wr) e.rdata = mem_m[addr[7:0]];
      else begin
        for (int i = 0; i < DATA_W/8; i++)
          if (be[i]) mem_m[addr[7:0]][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    sb.push_back(e);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // Counts falling-edge samples with busy high, starting now. Optionally
  // pulses clear_req mid-fill (must be ignored) or asserts reset at sample
  // abort_at. Returns the count; bounded.
  task automatic count_busy(input int pulse_at, input int abort_at, output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
      if (n == abort_at) return;
      clear_req = (n == pulse_at);
    end
  endtask

  task automatic expect_busy_len(input string name, input int n);
    tests_run++;
    if (n !== DEPTH) begin
      tests_failed++;
      $display("FAIL %s: got busy for %0d cycles, required %0d", name, n, DEPTH);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: got busy=%b ready=%b valid=%b rdata=%h err=%b, required all 0",
               name, busy, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic check_ready(input string name);
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: got ready=%b busy=%b, required ready=1 busy=0", name, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle(3);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    count_busy(-1, -1, n);
    expect_busy_len("reset_clear_len", n);
    @(posedge clk); #1;
    check_ready("ready_after_clear");
    model_clear();
    issue(1'b0, 16'h00FF, '0, 2'b00);
    issue(1'b0, 16'h0000, '0, 2'b00);
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 16'h0005, 16'h1234, 2'b11);
    issue(1'b1, 16'h0005, 16'hABCD, 2'b10);
    issue(1'b0, 16'h0005, '0, 2'b00);
    idle(1);
    issue(1'b1, 16'h0006, 16'hCAFE, 2'b01);
    issue(1'b0, 16'h0006, '0, 2'b00);
    issue(1'b1, 16'h00FF, 16'h7E57, 2'b11);
    issue(1'b0, 16'h00FF, '0, 2'b00);
  endtask

  task automatic test_be_zero();
    issue(1'b1, 16'h0005, 16'hFFFF, 2'b00);
    issue(1'b0, 16'h0005, '0, 2'b00);
  endtask

  task automatic test_out_of_range();
    issue(1'b0, 16'h0100, '0, 2'b00);
    issue(1'b1, 16'h0100, 16'h9999, 2'b11);
    issue(1'b1, 16'hFFFF, 16'h8888, 2'b11);
    issue(1'b0, 16'h0000, '0, 2'b00);
    issue(1'b0, 16'h0005, '0, 2'b00);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 16'h0007, 16'hBEEF, 2'b11);
    issue(1'b0, 16'h0007, '0, 2'b00);
    issue(1'b0, 16'h0007, '0, 2'b00);
    idle(2);
  endtask

  task automatic test_clear_same_edge();
    int n;
    clear_req = 1'b1;
    issue(1'b1, 16'h0003, 16'h5555, 2'b11);
    clear_req = 1'b0;
    // Requests during the fill must be ignored: no response expected.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0004;
    req_wdata = 16'h4444;
    req_be    = 2'b11;
    count_busy(50, -1, n);
    clear_req = 1'b0;
    req_valid = 1'b0;
    expect_busy_len("clear_req_len", n);
    model_clear();
    @(posedge clk); #1;
    check_ready("ready_after_clear_req");
    issue(1'b0, 16'h0003, '0, 2'b00);
    issue(1'b0, 16'h0004, '0, 2'b00);
  endtask

  task automatic test_reset_mid_clear();
    int n;
    issue(1'b1, 16'h0009, 16'h1111, 2'b11);
    idle(2);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    count_busy(-1, 100, n);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_clear_outputs");
    idle(2);
    rst_n = 1'b1;
    count_busy(-1, -1, n);
    expect_busy_len("restart_clear_len", n);
    model_clear();
    @(posedge clk); #1;
    issue(1'b0, 16'h0009, '0, 2'b00);
    issue(1'b0, 16'h00FF, '0, 2'b00);
    idle(2);
  endtask

  initial begin
    cyc          = 0;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_be       = '0;
    clear_req    = 1'b0;
    #1;
    test_reset();
    test_byte_enable();
    test_be_zero();
    test_out_of_range();
    test_back_to_back();
    test_clear_same_edge();
    test_reset_mid_clear();
    idle(3);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_rsp: got %0d responses still outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
